lsu_bus_ctrl: RTL and testbench
===============================

// Module: lsu_bus_ctrl
// PURPOSE
//  Sequences load/store requests from the execute stage onto the data-memory bus.
//  - Checks alignment; generates word address, byte strobes and lane-replicated write data.
//  - Runs the valid/ready address phase and waits for the response.
//  - Returns load data shifted and sign/zero-extended.
//  - Guards each transaction with a timeout.
//  Sits between the execute stage and the data-memory port; one outstanding access at a time.
// PARAMETERS
//  XLEN            32   data/address width; only 32 supported (elaboration error otherwise)
//  TIMEOUT_CYCLES  255  max cycles in REQ+WAIT before the access is abandoned with a fault
// PORTS
//  i_clk            in   1          clock, all state on rising edge
//  i_rst_n          in   1          reset, asynchronous assert, active-low
//  i_req_valid      in   1          execute stage presents a memory op
//  i_req_we         in   1          1=store, 0=load
//  i_req_size       in   2          00 byte, 01 half, 10 word, 11 illegal
//  i_req_unsigned   in   1          loads: zero-extend when 1
//  i_req_addr       in   XLEN       byte address
//  i_req_wdata      in   XLEN       store data (rs2), low bytes significant
//  o_req_ready      out  1          request accepted when valid&&ready
//  o_rsp_valid      out  1          one-cycle completion pulse
//  o_rsp_rdata      out  XLEN       extended load data; 0 for stores/errors
//  o_rsp_misalign   out  1          with rsp_valid: misaligned/illegal size, no bus access made
//  o_rsp_fault      out  1          with rsp_valid: bus error or timeout
//  o_bus_avalid     out  1          address phase valid
//  i_bus_aready     in   1          address phase accepted
//  o_bus_we         out  1          write enable
//  o_bus_addr       out  XLEN       word-aligned address (addr[1:0]=0)
//  o_bus_wdata      out  XLEN       lane-replicated store data
//  o_bus_wstrb      out  XLEN/8     byte strobes; 0 for loads
//  i_bus_rvalid     in   1          response (reads and writes), sampled only in WAIT
//  i_bus_rdata      in   XLEN       read data
//  i_bus_rerr       in   1          response error, qualified by rvalid
// BEHAVIOUR
//  - Reset: state IDLE, counter 0; all outputs 0 except o_req_ready=1.
//  - FSM IDLE->REQ->WAIT->RESP->IDLE. o_req_ready=1 only in IDLE. All outputs registered.
//  - IDLE, accept: latch op.
//    - Misaligned → RESP next cycle, misalign=1, no avalid. Misaligned means half addr[0]=1,
//      word addr[1:0]!=0, or size 11.
//    - Otherwise → REQ.
//  - REQ: avalid=1; addr/we/wdata/wstrb stable until aready. aready → WAIT, avalid=0.
//  - WAIT: rvalid → RESP, capture rdata and rerr (fault=rerr).
//  - RESP: rsp_valid=1 for exactly one cycle, flags valid, then IDLE.
//  - Min latency: accept cycle N, avalid N+1, aready N+1, rvalid N+2, rsp_valid N+3.
//  - Timeout: counter cleared on accept, +1 each REQ/WAIT cycle.
//    - At TIMEOUT_CYCLES: drop avalid → RESP, fault=1, rdata=0.
//    - rvalid arriving in IDLE/REQ/RESP is ignored (late responses dropped).
//  - Strobes: byte 4'b0001<<a[1:0]; half 4'b0011<<a[1:0]; word 4'b1111.
//  - Write data: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
//  - Load data:
//    - Shift rdata right by 8*a[1:0].
//    - Byte/half: sign-extend bit 7/15, or zero-extend if unsigned. Word passes through.
//  - Async reset asserted mid-transaction: outputs clear immediately, op abandoned;
//    first cycle after release is IDLE with ready=1.
// TESTING
//  1. LB signed @0x1003, rdata 0x8A00_0000 -> bus_addr 0x1000, wstrb 0, rsp_rdata 0xFFFF_FF8A, rsp at N+3
//  2. SH @0x2002 wdata 0x1234_ABCD -> bus_addr 0x2000, wstrb 4'b1100, wdata 0xABCD_ABCD, rsp_rdata 0
//  3. LW @0x3001 -> no avalid ever; rsp_valid at N+1 with misalign=1, fault=0; LHU size 11 same
//  4. aready low 3 cycles then high, rvalid 2 cycles later -> avalid/addr/wdata stable throughout; LHU @0x4002 rdata 0xF00D_0000 -> 0x0000_F00D
//  5. TIMEOUT_CYCLES=8, no rvalid -> rsp_valid fault=1 8 cycles after REQ entry; late rvalid ignored; next SW completes normally
//  6. rst_n low during WAIT -> outputs 0 and ready=1 same cycle; after release new LB succeeds

Source files
------------

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl
// Sequences one load/store at a time from the execute stage onto the
// data-memory bus. The alignment check, byte strobes, lane-replicated write
// data and load-data extraction are all done here, and a timeout guards
// every transaction.
//
// Ports
//   i_clk, i_rst_n      clock; asynchronous active-low reset
//   i_req_*             request from execute (valid/ready handshake)
//   o_rsp_*             one-cycle completion pulse with data and flags
//   o_bus_*/i_bus_*     data-memory address phase and response
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new op (o_req_ready=1)
// REQ   | address phase driven, waiting for i_bus_aready
// WAIT  | address accepted, waiting for i_bus_rvalid
// RESP  | o_rsp_valid pulse, then back to IDLE
//
// Every output comes straight from a flop. The *_d values are computed for
// the state being entered.

module lsu_bus_ctrl #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   input  logic              i_req_we,
   input  logic [1:0]        i_req_size,
   input  logic              i_req_unsigned,
   input  logic [XLEN-1:0]   i_req_addr,
   input  logic [XLEN-1:0]   i_req_wdata,
   output logic              o_req_ready,
   output logic              o_rsp_valid,
   output logic [XLEN-1:0]   o_rsp_rdata,
   output logic              o_rsp_misalign,
   output logic              o_rsp_fault,
   output logic              o_bus_avalid,
   input  logic              i_bus_aready,
   output logic              o_bus_we,
   output logic [XLEN-1:0]   o_bus_addr,
   output logic [XLEN-1:0]   o_bus_wdata,
   output logic [XLEN/8-1:0] o_bus_wstrb,
   input  logic              i_bus_rvalid,
   input  logic [XLEN-1:0]   i_bus_rdata,
   input  logic              i_bus_rerr
);

   generate
      if (XLEN != 32) begin : g_xlen_chk
         $error("lsu_bus_ctrl: only XLEN=32 is supported");
      end
      if (TIMEOUT_CYCLES < 1) begin : g_to_chk
         $error("lsu_bus_ctrl: TIMEOUT_CYCLES must be at least 1");
      end
   endgenerate

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   // latched op attributes needed after the address phase
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [1:0]        off_q, off_d;

   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic              rsp_misalign_q, rsp_misalign_d;
   logic              rsp_fault_q, rsp_fault_d;
   logic              bus_avalid_q, bus_avalid_d;
   logic              bus_we_q, bus_we_d;
   logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
   logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
   logic [XLEN/8-1:0] bus_wstrb_q, bus_wstrb_d;

   logic              req_misalign;
   logic [XLEN/8-1:0] req_wstrb;
   logic [XLEN-1:0]   req_wdata_rep;
   logic [XLEN-1:0]   rd_shift;
   logic [XLEN-1:0]   rd_ext;
   logic              cnt_expired;

   always_comb begin
      req_misalign  = 1'b0;
      req_wstrb     = '0;
      req_wdata_rep = i_req_wdata;
      case (i_req_size)
         2'b00: begin
            req_misalign  = 1'b0;
            req_wstrb     = 4'b0001 << i_req_addr[1:0];
            req_wdata_rep = {4{i_req_wdata[7:0]}};
         end
         2'b01: begin
            req_misalign  = i_req_addr[0];
            req_wstrb     = 4'b0011 << i_req_addr[1:0];
            req_wdata_rep = {2{i_req_wdata[15:0]}};
         end
         2'b10: begin
            req_misalign  = (i_req_addr[1:0] != 2'b00);
            req_wstrb     = 4'b1111;
            req_wdata_rep = i_req_wdata;
         end
         default: begin
            req_misalign  = 1'b1;
            req_wstrb     = '0;
            req_wdata_rep = i_req_wdata;
         end
      endcase
   end

   // Load data: bring the addressed lane down to bit 0, then extend.
   always_comb begin
      rd_shift = i_bus_rdata >> {off_q, 3'b000};
      rd_ext   = rd_shift;
      case (size_q)
         2'b00:   rd_ext = uns_q ? {24'h0, rd_shift[7:0]}
                                 : {{24{rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   rd_ext = uns_q ? {16'h0, rd_shift[15:0]}
                                 : {{16{rd_shift[15]}}, rd_shift[15:0]};
         default: rd_ext = rd_shift;
      endcase
   end

   assign cnt_expired = (cnt_q == CNT_LAST);

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      we_d           = we_q;
      size_d         = size_q;
      uns_d          = uns_q;
      off_d          = off_q;
      rsp_valid_d    = 1'b0;
      rsp_rdata_d    = '0;
      rsp_misalign_d = 1'b0;
      rsp_fault_d    = 1'b0;
      bus_avalid_d   = bus_avalid_q;
      bus_we_d       = bus_we_q;
      bus_addr_d     = bus_addr_q;
      bus_wdata_d    = bus_wdata_q;
      bus_wstrb_d    = bus_wstrb_q;

      case (state_q)
         S_IDLE: begin
            if (i_req_valid) begin
               we_d   = i_req_we;
               size_d = i_req_size;
               uns_d  = i_req_unsigned;
               off_d  = i_req_addr[1:0];
               cnt_d  = '0;
               if (req_misalign) begin
                  state_d        = S_RESP;
                  rsp_valid_d    = 1'b1;
                  rsp_misalign_d = 1'b1;
               end else begin
                  state_d      = S_REQ;
                  bus_avalid_d = 1'b1;
                  bus_we_d     = i_req_we;
                  bus_addr_d   = {i_req_addr[XLEN-1:2], 2'b00};
                  bus_wdata_d  = req_wdata_rep;
                  bus_wstrb_d  = i_req_we ? req_wstrb : '0;
               end
            end
         end
         S_REQ: begin
            // Timeout wins over a same-cycle aready: the op is abandoned
            // either way, and any later response lands in IDLE and is dropped.
            if (cnt_expired) begin
               state_d      = S_RESP;
               bus_avalid_d = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_fault_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (i_bus_aready) begin
                  state_d      = S_WAIT;
                  bus_avalid_d = 1'b0;
               end
            end
         end
         S_WAIT: begin
            // A response in the last allowed cycle still counts as on time.
            if (i_bus_rvalid) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_fault_d = i_bus_rerr;
               rsp_rdata_d = (i_bus_rerr || we_q) ? '0 : rd_ext;
            end else if (cnt_expired) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d      = S_IDLE;
            bus_avalid_d = 1'b0;
         end
      endcase

      req_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         we_q           <= 1'b0;
         size_q         <= 2'b00;
         uns_q          <= 1'b0;
         off_q          <= 2'b00;
         req_ready_q    <= 1'b1;
         rsp_valid_q    <= 1'b0;
         rsp_rdata_q    <= '0;
         rsp_misalign_q <= 1'b0;
         rsp_fault_q    <= 1'b0;
         bus_avalid_q   <= 1'b0;
         bus_we_q       <= 1'b0;
         bus_addr_q     <= '0;
         bus_wdata_q    <= '0;
         bus_wstrb_q    <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         we_q           <= we_d;
         size_q         <= size_d;
         uns_q          <= uns_d;
         off_q          <= off_d;
         req_ready_q    <= req_ready_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_rdata_q    <= rsp_rdata_d;
         rsp_misalign_q <= rsp_misalign_d;
         rsp_fault_q    <= rsp_fault_d;
         bus_avalid_q   <= bus_avalid_d;
         bus_we_q       <= bus_we_d;
         bus_addr_q     <= bus_addr_d;
         bus_wdata_q    <= bus_wdata_d;
         bus_wstrb_q    <= bus_wstrb_d;
      end
   end

   assign o_req_ready    = req_ready_q;
   assign o_rsp_valid    = rsp_valid_q;
   assign o_rsp_rdata    = rsp_rdata_q;
   assign o_rsp_misalign = rsp_misalign_q;
   assign o_rsp_fault    = rsp_fault_q;
   assign o_bus_avalid   = bus_avalid_q;
   assign o_bus_we       = bus_we_q;
   assign o_bus_addr     = bus_addr_q;
   assign o_bus_wdata    = bus_wdata_q;
   assign o_bus_wstrb    = bus_wstrb_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Testbench for lsu_bus_ctrl: hand-written vectors, timeout and reset
// sequences, then random ops checked against an arithmetic reference model.

module tb_lsu_bus_ctrl;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, rsp_valid, rsp_misalign, rsp_fault;
   logic [31:0] rsp_rdata;
   logic        bus_avalid, bus_aready, bus_we;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_wstrb;
   logic        bus_rvalid, bus_rerr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   lsu_bus_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_req_valid    (req_valid),
      .i_req_we       (req_we),
      .i_req_size     (req_size),
      .i_req_unsigned (req_unsigned),
      .i_req_addr     (req_addr),
      .i_req_wdata    (req_wdata),
      .o_req_ready    (req_ready),
      .o_rsp_valid    (rsp_valid),
      .o_rsp_rdata    (rsp_rdata),
      .o_rsp_misalign (rsp_misalign),
      .o_rsp_fault    (rsp_fault),
      .o_bus_avalid   (bus_avalid),
      .i_bus_aready   (bus_aready),
      .o_bus_we       (bus_we),
      .o_bus_addr     (bus_addr),
      .o_bus_wdata    (bus_wdata),
      .o_bus_wstrb    (bus_wstrb),
      .i_bus_rvalid   (bus_rvalid),
      .i_bus_rdata    (bus_rdata),
      .i_bus_rerr     (bus_rerr)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   typedef struct {
      string       nm;
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        rerr;
      int          ard;
      int          rvd;
      logic        mis;
      logic [31:0] e_addr;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata;
      logic [31:0] e_rdata;
   } vec_t;

   // Reference model: pure arithmetic on byte counts and lane offsets.
   function automatic vec_t model(input string nm, input logic we, input logic [1:0] size,
                                  input logic uns, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  input logic rerr, input int ard, input int rvd);
      vec_t v;
      int nb;
      int off;
      logic [31:0] mask, val;
      v.nm = nm; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
      v.wdata = wdata; v.rdata = rdata; v.rerr = rerr; v.ard = ard; v.rvd = rvd;
      nb  = 1 << size;
      off = int'(addr % 4);
      v.mis    = (size == 2'd3) || ((addr % nb) != 0);
      v.e_addr = addr - (addr % 4);
      v.e_strb = we ? 4'(((1 << nb) - 1) << off) : 4'h0;
      v.e_wdata = 32'h0;
      for (int i = 0; i < 4; i++)
         v.e_wdata = v.e_wdata | (((wdata >> (8 * (i % nb))) & 32'hFF) << (8 * i));
      if (we || size == 2'd3) begin
         v.e_rdata = 32'h0;
      end else begin
         val = rdata >> (8 * off);
         if (nb < 4) begin
            mask = (32'h1 << (8 * nb)) - 32'h1;
            val  = val & mask;
            if (!uns && val[8 * nb - 1]) val = val | ~mask;
         end
         v.e_rdata = val;
      end
      return v;
   endfunction

   task automatic run_op(input vec_t v);
      @(negedge clk);
      chk({v.nm, " ready"}, 32'(req_ready), 32'h1);
      req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
      req_addr = v.addr; req_wdata = v.wdata;
      @(negedge clk);
      // scramble request inputs so the bus side must come from latched state
      req_valid = 1'b0; req_addr = ~v.addr; req_wdata = ~v.wdata; req_we = ~v.we;
      if (v.mis) begin
         chk({v.nm, " mis rsp_valid"}, 32'(rsp_valid), 32'h1);
         chk({v.nm, " mis flag"}, 32'(rsp_misalign), 32'h1);
         chk({v.nm, " mis fault"}, 32'(rsp_fault), 32'h0);
         chk({v.nm, " mis rdata"}, rsp_rdata, 32'h0);
         chk({v.nm, " mis avalid"}, 32'(bus_avalid), 32'h0);
         @(negedge clk);
         chk({v.nm, " mis rsp_end"}, 32'(rsp_valid), 32'h0);
         chk({v.nm, " mis avalid2"}, 32'(bus_avalid), 32'h0);
         return;
      end
      for (int t = 0; t <= v.ard; t++) begin
         chk({v.nm, " avalid"}, 32'(bus_avalid), 32'h1);
         chk({v.nm, " addr"}, bus_addr, v.e_addr);
         chk({v.nm, " wstrb"}, 32'(bus_wstrb), 32'(v.e_strb));
         chk({v.nm, " we"}, 32'(bus_we), 32'(v.we));
         if (v.we) chk({v.nm, " wdata"}, bus_wdata, v.e_wdata);
         chk({v.nm, " early rsp"}, 32'(rsp_valid), 32'h0);
         bus_aready = (t == v.ard);
         @(negedge clk);
      end
      bus_aready = 1'b0;
      for (int j = 0; j <= v.rvd; j++) begin
         chk({v.nm, " avalid drop"}, 32'(bus_avalid), 32'h0);
         chk({v.nm, " wait rsp"}, 32'(rsp_valid), 32'h0);
         bus_rvalid = (j == v.rvd);
         bus_rdata  = (j == v.rvd) ? v.rdata : $urandom;
         bus_rerr   = (j == v.rvd) ? v.rerr : 1'b0;
         @(negedge clk);
      end
      bus_rvalid = 1'b0; bus_rerr = 1'b0; bus_rdata = $urandom;
      chk({v.nm, " rsp_valid"}, 32'(rsp_valid), 32'h1);
      chk({v.nm, " misalign"}, 32'(rsp_misalign), 32'h0);
      chk({v.nm, " fault"}, 32'(rsp_fault), 32'(v.rerr));
      chk({v.nm, " rdata"}, rsp_rdata, v.rerr ? 32'h0 : v.e_rdata);
      @(negedge clk);
      chk({v.nm, " rsp_end"}, 32'(rsp_valid), 32'h0);
      chk({v.nm, " ready_after"}, 32'(req_ready), 32'h1);
   endtask

   task automatic run_timeout(input string nm, input logic give_aready);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h0000_A000; req_wdata = 32'h0;
      @(negedge clk);
      req_valid = 1'b0;
      for (int t = 0; t < TO; t++) begin
         chk({nm, " no rsp"}, 32'(rsp_valid), 32'h0);
         if (!give_aready) chk({nm, " avalid held"}, 32'(bus_avalid), 32'h1);
         bus_aready = give_aready && (t == 0);
         @(negedge clk);
      end
      bus_aready = 1'b0;
      chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'h1);
      chk({nm, " fault"}, 32'(rsp_fault), 32'h1);
      chk({nm, " misalign"}, 32'(rsp_misalign), 32'h0);
      chk({nm, " rdata"}, rsp_rdata, 32'h0);
      chk({nm, " avalid"}, 32'(bus_avalid), 32'h0);
      // late response arriving in RESP and then in IDLE must be dropped
      bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk({nm, " late rsp1"}, 32'(rsp_valid), 32'h0);
      chk({nm, " ready"}, 32'(req_ready), 32'h1);
      @(negedge clk);
      bus_rvalid = 1'b0;
      chk({nm, " late rsp2"}, 32'(rsp_valid), 32'h0);
   endtask

   vec_t vecs[$];

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      bus_aready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0; bus_rerr = 1'b0;

      vecs.push_back('{"lb_1003", 1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 32'h8A00_0000, 1'b0, 0, 0,
                       1'b0, 32'h0000_1000, 4'h0, 32'h0, 32'hFFFF_FF8A});
      vecs.push_back('{"sh_2002", 1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 1'b0, 0, 0,
                       1'b0, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0});
      vecs.push_back('{"lw_3001", 1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0, 32'h0, 1'b0, 0, 0,
                       1'b1, 32'h0, 4'h0, 32'h0, 32'h0});
      vecs.push_back('{"size3", 1'b0, 2'd3, 1'b1, 32'h0000_3000, 32'h0, 32'h0, 1'b0, 0, 0,
                       1'b1, 32'h0, 4'h0, 32'h0, 32'h0});
      vecs.push_back('{"lhu_4002", 1'b0, 2'd1, 1'b1, 32'h0000_4002, 32'h0, 32'hF00D_0000, 1'b0, 3, 2,
                       1'b0, 32'h0000_4000, 4'h0, 32'h0, 32'h0000_F00D});
      vecs.push_back('{"sb_5001", 1'b1, 2'd0, 1'b0, 32'h0000_5001, 32'h0000_00A5, 32'h0, 1'b0, 1, 0,
                       1'b0, 32'h0000_5000, 4'b0010, 32'hA5A5_A5A5, 32'h0});
      vecs.push_back('{"lh_6000", 1'b0, 2'd1, 1'b0, 32'h0000_6000, 32'h0, 32'h1234_8001, 1'b0, 0, 1,
                       1'b0, 32'h0000_6000, 4'h0, 32'h0, 32'hFFFF_8001});
      vecs.push_back('{"lbu_7002", 1'b0, 2'd0, 1'b1, 32'h0000_7002, 32'h0, 32'h00C3_0000, 1'b0, 0, 0,
                       1'b0, 32'h0000_7000, 4'h0, 32'h0, 32'h0000_00C3});
      vecs.push_back('{"lw_8000", 1'b0, 2'd2, 1'b0, 32'h0000_8000, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0,
                       1'b0, 32'h0000_8000, 4'h0, 32'h0, 32'hDEAD_BEEF});
      vecs.push_back('{"sw_9000", 1'b1, 2'd2, 1'b0, 32'h0000_9000, 32'hCAFE_F00D, 32'h0, 1'b0, 0, 0,
                       1'b0, 32'h0000_9000, 4'b1111, 32'hCAFE_F00D, 32'h0});
      vecs.push_back('{"lh_1001", 1'b0, 2'd1, 1'b0, 32'h0000_1001, 32'h0, 32'h0, 1'b0, 0, 0,
                       1'b1, 32'h0, 4'h0, 32'h0, 32'h0});
      vecs.push_back('{"lw_rerr", 1'b0, 2'd2, 1'b0, 32'h0000_C000, 32'h0, 32'h1234_5678, 1'b1, 0, 0,
                       1'b0, 32'h0000_C000, 4'h0, 32'h0, 32'h0});

      @(negedge clk);
      @(negedge clk);
      chk("reset ready", 32'(req_ready), 32'h1);
      chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
      chk("reset avalid", 32'(bus_avalid), 32'h0);
      chk("reset addr", bus_addr, 32'h0);
      chk("reset wstrb", 32'(bus_wstrb), 32'h0);
      chk("reset rdata", rsp_rdata, 32'h0);
      rst_n = 1'b1;

      foreach (vecs[i]) run_op(vecs[i]);

      run_timeout("timeout_wait", 1'b1);
      run_op(model("sw_after_to", 1'b1, 2'd2, 1'b0, 32'h0000_D004, 32'h0BAD_CAFE, 32'h0, 1'b0, 0, 0));
      run_timeout("timeout_req", 1'b0);
      run_op(model("lw_after_to", 1'b0, 2'd2, 1'b0, 32'h0000_D008, 32'h0, 32'h7654_3210, 1'b0, 1, 1));

      // async reset while waiting for the response
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h0000_B000;
      req_wdata = 32'h1111_2222;
      @(negedge clk);
      req_valid = 1'b0;
      bus_aready = 1'b1;
      @(negedge clk);
      bus_aready = 1'b0;
      chk("rst pre avalid", 32'(bus_avalid), 32'h0);
      rst_n = 1'b0;
      #1;
      chk("rst ready", 32'(req_ready), 32'h1);
      chk("rst avalid", 32'(bus_avalid), 32'h0);
      chk("rst addr", bus_addr, 32'h0);
      chk("rst wstrb", 32'(bus_wstrb), 32'h0);
      chk("rst we", 32'(bus_we), 32'h0);
      chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
      @(negedge clk);
      bus_rvalid = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      bus_rvalid = 1'b0;
      chk("rst release ready", 32'(req_ready), 32'h1);
      chk("rst release rsp", 32'(rsp_valid), 32'h0);
      run_op(model("lb_after_rst", 1'b0, 2'd0, 1'b0, 32'h0000_E001, 32'h0, 32'h0000_9C00, 1'b0, 0, 0));

      for (int i = 0; i < 40; i++) begin
         logic [1:0]  sz;
         logic [31:0] a;
         sz = 2'($urandom_range(0, 3));
         a  = $urandom;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         run_op(model($sformatf("rnd%0d", i), 1'($urandom), sz, 1'($urandom), a, $urandom,
                      $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                      $urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
